// File: rtl/xmem_stream_wr.sv
// xmem_stream_wr: write-side strided address generator and stream sink.
// Words arrive on a valid/ready stream. Each accepted word becomes a one-cycle
// registered write strobe on the xmem DMA port, at addresses that follow the
// same iterations/period/duty/start/shift/incr/delay pattern that xmem reads use.
module xmem_stream_wr #(
    parameter int DATA_W     = 32,
    parameter int MEM_ADDR_W = 10,
    parameter int PERIOD_W   = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  init,
    input  logic                  run,
    output logic                  done,
    input  logic [MEM_ADDR_W-1:0] cfg_iter,
    input  logic [PERIOD_W-1:0]   cfg_period,
    input  logic [PERIOD_W-1:0]   cfg_duty,
    input  logic [PERIOD_W-1:0]   cfg_delay,
    input  logic [MEM_ADDR_W-1:0] cfg_start,
    input  logic [MEM_ADDR_W-1:0] cfg_shift,
    input  logic [MEM_ADDR_W-1:0] cfg_incr,
    input  logic                  in_valid,
    input  logic [DATA_W-1:0]     in_data,
    output logic                  in_ready,
    output logic                  data_mem_valid,
    output logic                  data_we,
    output logic [MEM_ADDR_W-1:0] data_addr,
    output logic [DATA_W-1:0]     data_data_in
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DELAY = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next_state;

    // Shadow copies of the configuration. r_duty holds min(duty, period).
    logic [MEM_ADDR_W-1:0] r_iter;
    logic [PERIOD_W-1:0]   r_period;
    logic [PERIOD_W-1:0]   r_duty;
    logic [PERIOD_W-1:0]   r_delay;
    logic [MEM_ADDR_W-1:0] r_shift;
    logic [MEM_ADDR_W-1:0] r_incr;

    // Pattern walkers.
    logic [MEM_ADDR_W-1:0] r_addr;
    logic [PERIOD_W-1:0]   r_p;
    logic [MEM_ADDR_W-1:0] r_k;
    logic [PERIOD_W-1:0]   r_dcnt;

    // Registered write port.
    logic                  r_mem_valid;
    logic [MEM_ADDR_W-1:0] r_addr_out;
    logic [DATA_W-1:0]     r_data_out;

    logic                  w_ready;
    logic                  w_done;
    logic                  w_hs;
    logic                  w_adv;
    logic                  w_zero_cfg;
    logic                  w_last_slot;
    logic                  w_last_iter;
    logic                  w_start;
    logic [PERIOD_W-1:0]   w_duty_eff;
    logic [MEM_ADDR_W-1:0] w_addr_inc;
    logic [MEM_ADDR_W-1:0] w_addr_step;

    assign w_duty_eff  = (cfg_duty < cfg_period) ? cfg_duty : cfg_period;
    assign w_zero_cfg  = (r_iter == '0) || (r_period == '0) || (r_duty == '0);
    assign w_start     = (r_state == S_IDLE) && !init && run && !w_zero_cfg;
    assign w_hs        = in_valid && w_ready;
    // Duty slots wait for a handshake; idle slots advance unconditionally.
    assign w_adv       = (r_state == S_RUN) && (w_ready ? in_valid : 1'b1);
    assign w_last_slot = (r_p == (r_period - PERIOD_W'(1)));
    assign w_last_iter = (r_k == (r_iter - MEM_ADDR_W'(1)));
    assign w_addr_inc  = w_hs ? r_incr : '0;
    assign w_addr_step = w_last_slot ? (w_addr_inc + r_shift) : w_addr_inc;

    assign in_ready       = w_ready;
    assign done           = w_done;
    assign data_mem_valid = r_mem_valid;
    assign data_we        = r_mem_valid;
    assign data_addr      = r_addr_out;
    assign data_data_in   = r_data_out;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode: start, delay countdown, end of pattern.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_next_state = (r_delay != '0) ? S_DELAY : S_RUN;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_DELAY: begin
                if (r_dcnt == '0) begin
                    w_next_state = S_RUN;
                end else begin
                    w_next_state = S_DELAY;
                end
            end
            S_RUN: begin
                if (w_adv && w_last_slot && w_last_iter) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_next_state = S_RUN;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Output decode: ready only in duty slots, done while idle.
    always_comb begin
        w_ready = 1'b0;
        w_done  = 1'b0;
        case (r_state)
            S_IDLE:  w_done  = 1'b1;
            S_DELAY: w_ready = 1'b0;
            S_RUN:   w_ready = (r_p < r_duty);
            default: w_done  = 1'b1;
        endcase
    end

    // Shadow config, slot/iteration/delay counters and running address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_iter   <= '0;
            r_period <= '0;
            r_duty   <= '0;
            r_delay  <= '0;
            r_shift  <= '0;
            r_incr   <= '0;
            r_addr   <= '0;
            r_p      <= '0;
            r_k      <= '0;
            r_dcnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (init) begin
                        r_iter   <= cfg_iter;
                        r_period <= cfg_period;
                        r_duty   <= w_duty_eff;
                        r_delay  <= cfg_delay;
                        r_shift  <= cfg_shift;
                        r_incr   <= cfg_incr;
                        r_addr   <= cfg_start;
                    end else if (w_start) begin
                        r_p    <= '0;
                        r_k    <= '0;
                        r_dcnt <= r_delay - PERIOD_W'(1);
                    end
                end
                S_DELAY: begin
                    if (r_dcnt != '0) begin
                        r_dcnt <= r_dcnt - PERIOD_W'(1);
                    end
                end
                S_RUN: begin
                    if (w_adv) begin
                        // Address is left where the pattern ends so a later
                        // run without init continues from it.
                        r_addr <= r_addr + w_addr_step;
                        if (w_last_slot) begin
                            r_p <= '0;
                            r_k <= w_last_iter ? '0 : (r_k + MEM_ADDR_W'(1));
                        end else begin
                            r_p <= r_p + PERIOD_W'(1);
                        end
                    end
                end
                default: begin
                    r_p <= '0;
                    r_k <= '0;
                end
            endcase
        end
    end

    // Registered write port: one strobe in the cycle after each handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_valid <= 1'b0;
            r_addr_out  <= '0;
            r_data_out  <= '0;
        end else begin
            r_mem_valid <= w_hs;
            if (w_hs) begin
                r_addr_out <= r_addr;
                r_data_out <= in_data;
            end
        end
    end

endmodule

// File: tb/tb_xmem_stream_wr.sv
// Randomized self-checking bench for xmem_stream_wr. A behavioural model
// predicts, per cycle, in_ready/done and the registered write strobe; the
// write addresses come from a queue expanded from the pattern rules.
module tb_xmem_stream_wr;
    localparam int DW = 32;
    localparam int AW = 10;
    localparam int PW = 10;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          init;
    logic          run;
    logic          done;
    logic [AW-1:0] cfg_iter;
    logic [PW-1:0] cfg_period;
    logic [PW-1:0] cfg_duty;
    logic [PW-1:0] cfg_delay;
    logic [AW-1:0] cfg_start;
    logic [AW-1:0] cfg_shift;
    logic [AW-1:0] cfg_incr;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          data_mem_valid;
    logic          data_we;
    logic [AW-1:0] data_addr;
    logic [DW-1:0] data_data_in;

    always #5 clk = ~clk;

    xmem_stream_wr #(.DATA_W(DW), .MEM_ADDR_W(AW), .PERIOD_W(PW)) dut (
        .clk(clk), .rst_n(rst_n), .init(init), .run(run), .done(done),
        .cfg_iter(cfg_iter), .cfg_period(cfg_period), .cfg_duty(cfg_duty),
        .cfg_delay(cfg_delay), .cfg_start(cfg_start), .cfg_shift(cfg_shift),
        .cfg_incr(cfg_incr), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .data_mem_valid(data_mem_valid), .data_we(data_we),
        .data_addr(data_addr), .data_data_in(data_data_in)
    );

    int errors = 0;
    int checks = 0;

    // Model state
    int            m_iter, m_period, m_duty, m_delay;
    logic [AW-1:0] m_shift, m_incr, m_addr;
    bit            busy;
    int            dl, p, k;
    logic [AW-1:0] aq[$];
    bit            last_hs;
    bit            tog;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int duty_eff();
        return (m_duty < m_period) ? m_duty : m_period;
    endfunction

    task automatic model_reset();
        m_iter = 0; m_period = 0; m_duty = 0; m_delay = 0;
        m_shift = '0; m_incr = '0; m_addr = '0;
        busy = 1'b0; dl = 0; p = 0; k = 0;
        aq.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_ready"}, 64'(in_ready), 64'd0);
        check({tag, "_valid"}, 64'(data_mem_valid), 64'd0);
        check({tag, "_we"}, 64'(data_we), 64'd0);
        check({tag, "_addr"}, 64'(data_addr), 64'd0);
        check({tag, "_data"}, 64'(data_data_in), 64'd0);
    endtask

    // One clock: check comb outputs, take the edge, advance model, check strobe.
    task automatic cycle();
        bit            mr, hs, start_run;
        logic [DW-1:0] ed;
        logic [AW-1:0] ea;
        mr = busy && (dl == 0) && (p < duty_eff());
        check("in_ready", 64'(in_ready), 64'(mr));
        check("done", 64'(done), 64'(!busy));
        hs = in_valid && mr;
        ed = in_data;
        start_run = 1'b0;
        if (!busy) begin
            if (init) begin
                m_iter = int'(cfg_iter); m_period = int'(cfg_period);
                m_duty = int'(cfg_duty); m_delay = int'(cfg_delay);
                m_shift = cfg_shift; m_incr = cfg_incr; m_addr = cfg_start;
            end else if (run && m_iter != 0 && duty_eff() != 0) begin
                start_run = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        if (busy) begin
            if (dl > 0) begin
                dl--;
            end else if (p >= duty_eff() || hs) begin
                p++;
                if (p == m_period) begin
                    p = 0;
                    k++;
                    if (k == m_iter) busy = 1'b0;
                end
            end
        end
        if (start_run) begin
            busy = 1'b1; dl = m_delay; p = 0; k = 0;
            for (int ii = 0; ii < m_iter; ii++) begin
                for (int pp = 0; pp < m_period; pp++) begin
                    if (pp < duty_eff()) begin
                        aq.push_back(m_addr);
                        m_addr = m_addr + m_incr;
                    end
                end
                m_addr = m_addr + m_shift;
            end
        end
        check("mem_valid", 64'(data_mem_valid), 64'(hs));
        check("we", 64'(data_we), 64'(hs));
        if (hs) begin
            ea = (aq.size() > 0) ? aq.pop_front() : '0;
            check("addr", 64'(data_addr), 64'(ea));
            check("data", 64'(data_data_in), 64'(ed));
        end
        last_hs = hs;
    endtask

    task automatic do_cfg(input int it, input int per, input int du, input int de,
                          input int st, input int sh, input int inc);
        cfg_iter = AW'(it); cfg_period = PW'(per); cfg_duty = PW'(du);
        cfg_delay = PW'(de); cfg_start = AW'(st); cfg_shift = AW'(sh);
        cfg_incr = AW'(inc);
        init = 1'b1;
        cycle();
        init = 1'b0;
    endtask

    function automatic logic pick_valid(input int mode);
        if (mode == 0) return 1'b1;
        if (mode == 1) return tog;
        return ($urandom_range(0, 3) != 0);
    endfunction

    // Issue run and stream words until the model goes idle; stop_after > 0
    // leaves the run after that many handshakes.
    task automatic do_run(input int mode, input logic [DW-1:0] base, input int stop_after);
        logic [DW-1:0] word;
        int            n, budget;
        word = base; n = 0; tog = 1'b1;
        in_data = word; in_valid = pick_valid(mode);
        run = 1'b1;
        cycle();
        run = 1'b0;
        budget = 0;
        while (busy && budget < 3000 && !(stop_after > 0 && n >= stop_after)) begin
            tog = ~tog;
            in_valid = pick_valid(mode);
            in_data = word;
            cycle();
            if (last_hs) begin
                word++;
                n++;
            end
            budget++;
        end
        if (budget >= 3000) check("timeout", 64'd1, 64'd0);
        in_valid = 1'b0;
        if (stop_after == 0) begin
            cycle();
            check("queue_empty", 64'(aq.size()), 64'd0);
        end
    endtask

    initial begin
        rst_n = 1'b0; init = 1'b0; run = 1'b0; in_valid = 1'b0; in_data = '0;
        cfg_iter = '0; cfg_period = '0; cfg_duty = '0; cfg_delay = '0;
        cfg_start = '0; cfg_shift = '0; cfg_incr = '0;
        model_reset();
        #12;
        check_reset_outputs("rst");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 3x3 block of a 5x5 map, continuous stream
        do_cfg(3, 3, 3, 0, 0, 2, 1);
        do_run(0, 32'd100, 0);
        // Idle slots
        do_cfg(2, 4, 2, 0, 0, 0, 1);
        do_run(0, 32'd200, 0);
        // Backpressure, toggling valid
        do_cfg(3, 3, 3, 0, 0, 2, 1);
        do_run(1, 32'd100, 0);
        // Second run without init continues from the current address
        do_run(0, 32'd300, 0);
        // Zero iterations: nothing happens
        do_cfg(0, 3, 3, 0, 0, 2, 1);
        do_run(0, 32'd400, 0);
        for (int i = 0; i < 3; i++) cycle();
        // Wrap and delay
        do_cfg(1, 4, 4, 3, 1022, 0, 1);
        do_run(0, 32'd500, 0);
        // init and run together: init wins
        cfg_iter = AW'(2); cfg_period = PW'(2); cfg_duty = PW'(1); cfg_delay = '0;
        cfg_start = AW'(7); cfg_shift = AW'(1); cfg_incr = AW'(3);
        init = 1'b1; run = 1'b1;
        cycle();
        init = 1'b0; run = 1'b0;
        cycle();
        do_run(2, 32'd600, 0);

        // Reset mid-run after the 4th strobe
        do_cfg(3, 3, 3, 0, 0, 2, 1);
        do_run(0, 32'd100, 4);
        check("mid_strobe", 64'(data_mem_valid), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        model_reset();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cycle();
        do_cfg(3, 3, 3, 0, 0, 2, 1);
        do_run(0, 32'd100, 0);

        // Randomized configurations and stream gaps
        for (int r = 0; r < 25; r++) begin
            if (r == 0 || $urandom_range(0, 4) != 0) begin
                do_cfg($urandom_range(0, 3), $urandom_range(0, 5), $urandom_range(0, 6),
                       $urandom_range(0, 3), $urandom_range(0, 1023),
                       $urandom_range(0, 1023), $urandom_range(0, 1023));
            end
            do_run(2, $urandom, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/xmem_stream_wr.md
# xmem_stream_wr

Write-side address generator and stream sink for an xmem port. It accepts a valid/ready data stream, walks the same strided pattern xmem uses for reads (iterations/period/duty/start/shift/incr/delay), and drives the xmem DMA write interface (`data_mem_valid`, `data_we`, `data_addr`, `data_data_in`). It is the writer counterpart of the xmem read flow and sits between a producer stream and an xmem instance.

## Interface
- `DATA_W`, default 32: stream and memory word width.
- `MEM_ADDR_W`, default 10: memory address width; also the width of the iterations field.
- `PERIOD_W`, default 10: width of the period, duty and delay fields.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `init`  in  1  latches the `cfg_*` inputs and loads the address with `cfg_start`.
- `run`  in  1  starts the pattern.
- `done`  out  1  high while idle.
- `cfg_iter`  in  MEM_ADDR_W  number of periods.
- `cfg_period`  in  PERIOD_W  slots per period.
- `cfg_duty`  in  PERIOD_W  active (write) slots per period.
- `cfg_delay`  in  PERIOD_W  cycles to wait after `run`.
- `cfg_start`, `cfg_shift`, `cfg_incr`  in  MEM_ADDR_W each  start address, per-period shift, per-write increment.
- `in_valid`  in  1  stream word valid.
- `in_data`  in  DATA_W  stream word.
- `in_ready`  out  1  block accepts a word.
- `data_mem_valid`  out  1  memory access strobe.
- `data_we`  out  1  write enable.
- `data_addr`  out  MEM_ADDR_W  write address.
- `data_data_in`  out  DATA_W  write data.

## Operation
- States: IDLE, DELAY, RUN.
- `init` in IDLE copies all `cfg_*` into shadow registers and sets `addr = cfg_start`. `init` outside IDLE is ignored. If `init` and `run` are high together, `init` wins and `run` is ignored.
- `run` in IDLE:
  - if the shadow iter, period or duty is 0, stay in IDLE with no writes;
  - else if delay > 0, go to DELAY;
  - else go to RUN.
- `run` outside IDLE is ignored.
- DELAY counts delay cycles, then goes to RUN.
- RUN keeps a slot counter `p` (0..period-1) and an iteration counter `k` (0..iter-1).
- Effective duty = min(duty, period).
- Duty slot (`p < duty`):
  - `in_ready = 1`;
  - the slot advances only on handshake (`in_valid & in_ready`);
  - on handshake the write is issued at `addr`, then `addr += incr`.
- Idle slot (`p >= duty`): `in_ready = 0`; `p` advances every cycle.
- End of period (`p == period-1` advancing): `p = 0`, `addr += shift`, `k++`.
- After the last slot of the last period, go to IDLE.
- Address arithmetic is modulo 2^MEM_ADDR_W; `incr` and `shift` are two's-complement, so negative strides wrap.
- `data_we` always equals `data_mem_valid`. The block never reads memory.
- `addr` is not reloaded at completion. A second `run` without `init` continues from the current `addr`.

## Timing
- Reset values:
  - `done = 1`, `in_ready = 0`;
  - `data_mem_valid = 0`, `data_we = 0`, `data_addr = 0`, `data_data_in = 0`;
  - state IDLE, all counters and shadow registers 0.
- `rst_n` asserted mid-operation aborts immediately. No partial write strobe survives.
- `in_ready` is a combinational decode of state and `p`. It never depends on `in_valid`.
- `run` sampled at edge E0:
  - `done` falls at E0 (unless iter, period or duty is 0, in which case `done` stays 1);
  - delay = 0: `in_ready` is first high in the cycle after E0;
  - delay = d: `in_ready` is first high d cycles later.
- Write outputs are registered. A handshake at edge E drives `data_mem_valid`, `data_we`, `data_addr` and `data_data_in` during the cycle after E, for exactly one cycle per handshake. Back-to-back handshakes give back-to-back strobes.
- `done` rises at the edge that accepts the final handshake, so it is high in the same cycle as the final write strobe.
- If period > duty at the end, `done` rises after the trailing idle slots instead.
- Throughput: one word per cycle during duty slots.

## Test plan
- 3x3 block of a 5x5 map:
  - config: start 0, iter 3, period 3, duty 3, shift 2, incr 1, delay 0;
  - stimulus: words 100..108 with continuous `in_valid`;
  - required: strobes at addresses 0,1,2,5,6,7,10,11,12 with data 100..108, 9 consecutive cycles; `done` high in the 9th strobe cycle.
- Idle slots:
  - config: iter 2, period 4, duty 2, incr 1, shift 0, start 0;
  - required: addresses 0,1,2,3; `in_ready` low for exactly 2 cycles between words 1 and 2.
- Backpressure:
  - stimulus: run the 3x3 case with `in_valid` toggling 1,0,1,0;
  - required: the same 9 address/data pairs, strobes only one cycle after each handshake, no skipped addresses.
- Zero iterations:
  - config: iter 0;
  - required: `done` stays 1, `in_ready` stays 0, no strobes.
- Wrap and delay:
  - config: start 1022, incr 1, iter 1, period 4, duty 4, delay 3;
  - required: `in_ready` first high 3 cycles after the `run` edge; addresses 1022,1023,0,1.
- Reset mid-run:
  - stimulus: deassert-then-reassert `rst_n` after the 4th strobe of the 3x3 case;
  - required: all outputs return to reset values immediately; `done = 1`; `init` plus `run` then restarts the pattern at address 0.
